dmem_resp: RTL
==============

Name: dmem_resp

Overview:
- Data-memory responder: the memory-side end of the load/store request interface.
- Accepts one load or store request per cycle via valid/ready and owns a word-organised synchronous scratchpad RAM.
- Stores: applies byte lanes. Loads: aligns and sign/zero-extends read data. Returns one response per request with valid/ready backpressure and an error flag for misaligned or out-of-range accesses.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4-aligned.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder accepts request this cycle
- req_we  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- req_size  in  2  mem_size_t: SZ_B=0, SZ_H=1, SZ_W=2; 3 is illegal
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts response
- resp_rdata  out  32  formatted load data; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal-size request

Behaviour:
- Reset (rst_n low at clk edge):
  - state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=0 while rst_n=0, so nothing is accepted in that cycle.
  - A pending response is dropped. RAM contents are not reset.
- Handshake:
  - Accept = req_valid & req_ready.
  - Response = resp_valid & resp_ready.
  - req_ready = rst_n & (state==IDLE | (state==RESP & resp_ready)).
  - One request is outstanding at most; throughput is 1/cycle while resp_ready stays high.
- FSM with two states:
  - IDLE: on accept -> RESP, otherwise stay.
  - RESP: resp_valid=1. If resp_ready & accept -> RESP with the new request. If resp_ready & !accept -> IDLE. If !resp_ready -> stay; outputs held stable.
- Latency: response is visible exactly 1 cycle after the accept edge.
- Error check at accept, registered with the request:
  - err if req_size==3.
  - err if SZ_H & addr[0].
  - err if SZ_W & addr[1:0]!=0.
  - err if (addr-BASE_ADDR) >= DEPTH_WORDS*4, computed as unsigned 32-bit; addresses below BASE wrap and fail.
  - An erroring store does not write; an erroring request still produces a response with resp_err=1 and resp_rdata=0.
- Word index = (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Stores:
  - Written at the accept edge.
  - byte enables: SZ_B -> 1<<addr[1:0]; SZ_H -> 2'b11<<addr[1:0]; SZ_W -> 4'hF.
  - Write data: byte replicated to all four lanes, half replicated to both halves.
  - Response carries resp_rdata=0.
- Loads:
  - RAM read enable asserted only on load accept, so the RAM output holds during backpressure.
  - addr[1:0], size and unsigned are registered at accept.
  - Response shifts the RAM word right by 8*addr[1:0], then extends from bit 7 (B) or bit 15 (H) per req_unsigned. SZ_W is passed through.
- Back-to-back store then load to the same word: the load sees the stored data (write at edge N, read at edge N+1). No forwarding path is needed.
- Reset asserted while in RESP with resp_ready low: the response is lost, and the requester must reissue after reset.

Decomposition:
- Add to the shared defines package: mem_size_t enum (SZ_B, SZ_H, SZ_W) and the resp FSM state enum.
- One sub-module: dmem_ram. It is a single-port synchronous RAM with parameters DEPTH_WORDS, ports clk, en, we, be[3:0], addr, wdata, rdata, and rdata held when en=0.
- Formatting and error logic stay in dmem_resp.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 with resp_ready=1 -> responses on consecutive cycles; second has rdata=0xDEADBEEF, err=0; req_ready stays 1.
- Then LB @0x13 signed -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
- SB 0x12 @0x11 then LW @0x10 -> 0xDEAD12EF (only lane 1 written).
- LW @0x12, LH @0x11, req_size=3, and LW @BASE+DEPTH_WORDS*4 -> each gives resp_err=1, rdata=0; a following LW @0x10 confirms no write occurred.
- Load accepted, resp_ready held 0 for 3 cycles while req_valid=1 -> resp_valid and resp_rdata stable, req_ready=0, no new accept; on resp_ready=1, the next request is accepted the same cycle.
- rst_n=0 while in RESP with resp_ready=0 -> next cycle resp_valid=0, resp_err=0, req_ready=0; after rst_n=1, previously stored RAM data still reads back.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_t;

  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  // Response FSM states
  typedef logic [0:0] resp_state_t;
  localparam resp_state_t ST_IDLE = 1'b0;
  localparam resp_state_t ST_RESP = 1'b1;

  // Byte-lane enables for a store of the given size at byte offset off.
  function automatic logic [3:0] byte_en(mem_size_t sz, logic [1:0] off);
    case (sz)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      default: return 4'hF;
    endcase
  endfunction

  // Right-align the addressed byte/half of a RAM word and extend it.
  function automatic logic [31:0] load_fmt(logic [31:0] word, logic [1:0] off,
                                           mem_size_t sz, logic uns);
    logic [15:0] sh;
    sh = 16'(word >> {off, 3'b000});
    case (sz)
      SZ_B:    return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    return uns ? {16'h0, sh}      : {{16{sh[15]}}, sh};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, one byte array per lane; read data holds when en=0.
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int NUM_LANES = 4;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_q;

    // Per-lane write on enabled stores, registered read on loads
    always_ff @(posedge clk) begin
      if (en) begin
        if (we) begin
          if (be[l]) mem[addr] <= wdata[l*8 +: 8];
        end else begin
          rd_q <= mem[addr];
        end
      end
    end

    assign rdata[l*8 +: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: valid/ready load/store front end over a scratchpad RAM.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

  resp_state_t state;
  mem_size_t   sz;
  logic [31:0] off;
  logic        err, accept, ram_en;
  logic [31:0] wdata_rep, ram_rdata;
  logic        r_err, r_we, r_uns;
  logic [1:0]  r_lane;
  mem_size_t   r_size;

  // BASE_ADDR is span-aligned, so off[1:0] equals the address byte offset;
  // addresses below BASE wrap high and fail the range check.
  assign off    = req_addr - BASE_ADDR;
  assign sz     = mem_size_t'(req_size);
  assign err    = (req_size == SZ_ILLEGAL)
                | (req_size == SZ_H && off[0])
                | (req_size == SZ_W && off[1:0] != 2'b00)
                | ({1'b0, off} >= SPAN);

  assign req_ready = rst_n & ((state == ST_IDLE) | ((state == ST_RESP) & resp_ready));
  assign accept    = req_valid & req_ready;
  assign ram_en    = accept & ~err;

  // Replicate narrow store data across lanes; byte enables pick the target
  always_comb begin
    wdata_rep = req_wdata;
    case (sz)
      SZ_B:    wdata_rep = {4{req_wdata[7:0]}};
      SZ_H:    wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (req_we),
    .be    (byte_en(sz, off[1:0])),
    .addr  (off[AW+1:2]),
    .wdata (wdata_rep),
    .rdata (ram_rdata)
  );

  // FSM and per-request attributes captured at accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      r_err  <= 1'b0;
      r_we   <= 1'b0;
      r_uns  <= 1'b0;
      r_lane <= 2'b00;
      r_size <= SZ_W;
    end else begin
      if (accept) begin
        state  <= ST_RESP;
        r_err  <= err;
        r_we   <= req_we;
        r_uns  <= req_unsigned;
        r_lane <= off[1:0];
        r_size <= sz;
      end else if (resp_ready) begin
        state <= ST_IDLE;
      end
    end
  end

  assign resp_valid = (state == ST_RESP);
  assign resp_err   = resp_valid & r_err;
  assign resp_rdata = (resp_valid & ~r_err & ~r_we)
                    ? load_fmt(ram_rdata, r_lane, r_size, r_uns) : 32'h0;

endmodule
